pwr_seq_ctrl: RTL and testbench

- Parametrised power-domain sequencer for the pad ring and core supplies.
- Enables NUM_DOM domains in ascending index order and disables them in reverse. For each domain it debounces the power-good, enforces a timeout and drives the matching ESD clamp/isolation enable.
- Sits beside the power pads in the top level. Core logic reads all_good_o as its release condition.

---
 rtl/pwr_seq_pkg.sv | 32 +++
 rtl/pgood_debounce.sv | 60 ++++++
 rtl/pwr_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_pwr_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_seq_pkg.sv
// ---------------------------------------------------------------------------
// pwr_seq_pkg
// Shared definitions for the power-domain sequencer:
//   - pwr_state_e   : sequencer FSM state encoding
//   - DOM_EN_SAFE   : per-bit supply enable value in the safe (unpowered) state
//   - CLAMP_SAFE    : per-bit clamp/isolation value in the safe state
//   - state_is_busy : true while an up or down sequence is running
// ---------------------------------------------------------------------------
package pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_UP_EN     = 3'd1,
        ST_UP_WAIT   = 3'd2,
        ST_UP_SETTLE = 3'd3,
        ST_ON        = 3'd4,
        ST_DN_CLAMP  = 3'd5,
        ST_DN_SETTLE = 3'd6,
        ST_FAULT     = 3'd7
    } pwr_state_e;

    // Idle / emergency output levels, replicated per domain by the user.
    localparam logic DOM_EN_SAFE = 1'b0;
    localparam logic CLAMP_SAFE  = 1'b1;

    function automatic logic state_is_busy(input pwr_state_e s);
        return (s == ST_UP_EN)     || (s == ST_UP_WAIT)  ||
               (s == ST_UP_SETTLE) || (s == ST_DN_CLAMP) ||
               (s == ST_DN_SETTLE);
    endfunction

endpackage

// File: rtl/pgood_debounce.sv
// ---------------------------------------------------------------------------
// pgood_debounce
// One-bit power-good conditioner: 2-flop synchroniser followed by a
// debouncer. The debounced output flips only after DEB_CYC consecutive
// synchronised samples that differ from it; any bounce restarts the count.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (output and counter cleared)
//   raw_i  : raw asynchronous power-good
//   deb_o  : debounced power-good
// ---------------------------------------------------------------------------
module pgood_debounce #(
    parameter int CNT_W   = 16,
    parameter int DEB_CYC = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

    logic             meta_q;
    logic             sync_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter never exceeds DEB_LAST, so it cannot wrap.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q != deb_q) begin
            if (cnt_q == DEB_LAST) begin
                deb_d = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pwr_seq_ctrl
// Power-domain sequencer. Enables NUM_DOM domains in ascending order and
// disables them in reverse, waiting for each debounced power-good and
// settling STEP_DLY cycles per step. A missing power-good (TIMEOUT) or a
// brown-out while ON latches a fault that drops every supply at once.
// Ports:
//   wb_clk_i     : clock
//   wb_rst_i     : synchronous active-high reset
//   pwr_req_i    : 1 = power up, 0 = power down
//   pgood_i      : raw asynchronous power-good per domain
//   fault_clr_i  : fault clear pulse (honoured only in FAULT with pwr_req_i=0)
//   dom_en_o     : domain supply enables
//   clamp_en_o   : clamp/isolation enables, high while a domain is unpowered
//   all_good_o   : all domains up and settled
//   busy_o       : sequence in progress
//   fault_o      : fault latched
//   fault_dom_o  : index of the faulting domain
// ---------------------------------------------------------------------------
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int  NUM_DOM  = 4,
    parameter int  CNT_W    = 16,
    parameter int  DEB_CYC  = 8,
    parameter int  STEP_DLY = 32,
    parameter int  TIMEOUT  = 1024,
    localparam int IDX_W    = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               pwr_req_i,
    input  logic [NUM_DOM-1:0] pgood_i,
    input  logic               fault_clr_i,
    output logic [NUM_DOM-1:0] dom_en_o,
    output logic [NUM_DOM-1:0] clamp_en_o,
    output logic               all_good_o,
    output logic               busy_o,
    output logic               fault_o,
    output logic [IDX_W-1:0]   fault_dom_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOM - 1);

    pwr_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NUM_DOM-1:0] dom_en_q, dom_en_d;
    logic [NUM_DOM-1:0] clamp_q, clamp_d;
    logic [IDX_W-1:0]   fault_dom_q, fault_dom_d;
    logic [NUM_DOM-1:0] pg_deb;
    logic               pg_lost;
    logic [IDX_W-1:0]   pg_lost_idx;

    // ------------------------------------------------------------------
    // Per-domain input conditioning
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DOM; gi++) begin : gen_deb
            pgood_debounce #(
                .CNT_W   (CNT_W),
                .DEB_CYC (DEB_CYC)
            ) u_deb (
                .clk_i (wb_clk_i),
                .rst_i (wb_rst_i),
                .raw_i (pgood_i[gi]),
                .deb_o (pg_deb[gi])
            );
        end
    endgenerate

    // Lowest-index domain whose debounced power-good is low. In ON every
    // domain was seen high, so a low bit here means it has fallen.
    always_comb begin
        pg_lost     = 1'b0;
        pg_lost_idx = '0;
        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (!pg_deb[i]) begin
                pg_lost     = 1'b1;
                pg_lost_idx = IDX_W'(i);
            end
        end
    end

    // Saturating increment: the counter holds at all-ones rather than wrap.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            cnt_q       <= '0;
            dom_en_q    <= {NUM_DOM{DOM_EN_SAFE}};
            clamp_q     <= {NUM_DOM{CLAMP_SAFE}};
            fault_dom_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            dom_en_q    <= dom_en_d;
            clamp_q     <= clamp_d;
            fault_dom_q <= fault_dom_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        dom_en_d    = dom_en_q;
        clamp_d     = clamp_q;
        fault_dom_d = fault_dom_q;

        case (state_q)
            ST_OFF: begin
                if (pwr_req_i) begin
                    state_d = ST_UP_EN;
                    idx_d   = '0;
                end
            end

            ST_UP_EN: begin
                // An abort keeps idx so the unwind starts at this domain.
                if (!pwr_req_i) begin
                    state_d = ST_DN_CLAMP;
                end else begin
                    dom_en_d[idx_q] = 1'b1;
                    cnt_d           = '0;
                    state_d         = ST_UP_WAIT;
                end
            end

            ST_UP_WAIT: begin
                if (!pwr_req_i) begin
                    state_d = ST_DN_CLAMP;
                end else if (pg_deb[idx_q]) begin
                    cnt_d   = '0;
                    state_d = ST_UP_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    fault_dom_d = idx_q;
                    dom_en_d    = {NUM_DOM{DOM_EN_SAFE}};
                    clamp_d     = {NUM_DOM{CLAMP_SAFE}};
                    state_d     = ST_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_UP_SETTLE: begin
                if (!pwr_req_i) begin
                    state_d = ST_DN_CLAMP;
                end else if (cnt_q == STEP_LAST) begin
                    clamp_d[idx_q] = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_ON;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_UP_EN;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_ON: begin
                // Brown-out outranks a power-down request.
                if (pg_lost) begin
                    fault_dom_d = pg_lost_idx;
                    dom_en_d    = {NUM_DOM{DOM_EN_SAFE}};
                    clamp_d     = {NUM_DOM{CLAMP_SAFE}};
                    state_d     = ST_FAULT;
                end else if (!pwr_req_i) begin
                    idx_d   = IDX_LAST;
                    state_d = ST_DN_CLAMP;
                end
            end

            ST_DN_CLAMP: begin
                clamp_d[idx_q] = 1'b1;
                cnt_d          = '0;
                state_d        = ST_DN_SETTLE;
            end

            ST_DN_SETTLE: begin
                if (cnt_q == STEP_LAST) begin
                    dom_en_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_DN_CLAMP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_FAULT: begin
                if (fault_clr_i && !pwr_req_i) begin
                    fault_dom_d = '0;
                    state_d     = ST_OFF;
                end
            end

            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        dom_en_o   = dom_en_q;
        clamp_en_o = clamp_q;
        all_good_o = 1'b0;
        busy_o     = state_is_busy(state_q);
        fault_o    = 1'b0;
        if (state_q == ST_FAULT) begin
            dom_en_o   = {NUM_DOM{DOM_EN_SAFE}};
            clamp_en_o = {NUM_DOM{CLAMP_SAFE}};
            fault_o    = 1'b1;
        end
        if (state_q == ST_ON) begin
            all_good_o = 1'b1;
        end
    end

    assign fault_dom_o = fault_dom_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwr_seq_ctrl
// Scoreboard bench. Each scenario derives, from the sequencing rules, the
// list of output snapshots the sequencer should present and the cycle of
// each; a monitor compares every change of the DUT outputs against the head
// of that list. A small plant model raises each pgood a random number of
// cycles after its enable and can hold or pulse it low.
// ---------------------------------------------------------------------------
module tb_pwr_seq_ctrl;

    localparam int ND   = 4;
    localparam int DEB  = 4;
    localparam int STEP = 8;
    localparam int TOUT = 64;

    typedef struct {
        int            t;
        logic [ND-1:0] dom;
        logic [ND-1:0] clamp;
        logic          ag;
        logic          busy;
        logic          flt;
        logic [1:0]    fdom;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          clr;
    logic [ND-1:0] pgood;
    logic [ND-1:0] dom_en;
    logic [ND-1:0] clamp;
    logic          all_good;
    logic          busy;
    logic          fault;
    logic [1:0]    fdom;

    int            cyc = 0;
    int            compared = 0;
    int            mismatched = 0;
    bit            mon_en = 1'b0;

    ev_t           exp_q[$];
    ev_t           mdl;
    ev_t           last_push;
    ev_t           reset_ev;

    int            d[ND];
    int            pc[ND];
    int            t_dom[ND];
    logic [ND-1:0] hold;
    logic [ND-1:0] force_low;

    pwr_seq_ctrl #(
        .NUM_DOM  (ND),
        .CNT_W    (16),
        .DEB_CYC  (DEB),
        .STEP_DLY (STEP),
        .TIMEOUT  (TOUT)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .pwr_req_i   (req),
        .pgood_i     (pgood),
        .fault_clr_i (clr),
        .dom_en_o    (dom_en),
        .clamp_en_o  (clamp),
        .all_good_o  (all_good),
        .busy_o      (busy),
        .fault_o     (fault),
        .fault_dom_o (fdom)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plant: pgood[i] rises d[i] cycles after dom_en[i] and drops with it.
    initial begin
        pgood = '0;
        for (int i = 0; i < ND; i++) pc[i] = 0;
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < ND; i++) begin
                if (dom_en[i]) begin
                    if (pc[i] < 1000) pc[i] = pc[i] + 1;
                    pgood[i] = (pc[i] >= d[i]) && !hold[i] && !force_low[i];
                end else begin
                    pc[i]    = 0;
                    pgood[i] = 1'b0;
                end
            end
        end
    end

    function automatic bit same_vals(input ev_t a, input ev_t b);
        return (a.dom === b.dom) && (a.clamp === b.clamp) && (a.ag === b.ag) &&
               (a.busy === b.busy) && (a.flt === b.flt) && (a.fdom === b.fdom);
    endfunction

    function automatic ev_t sample();
        ev_t s;
        s.t = cyc; s.dom = dom_en; s.clamp = clamp; s.ag = all_good;
        s.busy = busy; s.flt = fault; s.fdom = fdom;
        return s;
    endfunction

    task automatic show_fail(input string name, input ev_t got, input ev_t want);
        $display("FAIL %s: got t=%0d dom=%b clamp=%b ag=%b busy=%b flt=%b fdom=%0d, want t=%0d dom=%b clamp=%b ag=%b busy=%b flt=%b fdom=%0d",
                 name, got.t, got.dom, got.clamp, got.ag, got.busy, got.flt, got.fdom,
                 want.t, want.dom, want.clamp, want.ag, want.busy, want.flt, want.fdom);
    endtask

    // Monitor: every change of the output snapshot is one transaction.
    initial begin
        ev_t prev;
        ev_t cur;
        ev_t e;
        bit  have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge clk);
            cur = sample();
            if (mon_en && have_prev && !same_vals(cur, prev)) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    show_fail("unexpected_change", cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (!same_vals(cur, e) || cur.t != e.t || ((~cur.dom & ~cur.clamp) != '0)) begin
                        mismatched++;
                        show_fail("output_event", cur, e);
                    end else begin
                        $display("ok   t=%0d dom=%b clamp=%b ag=%b busy=%b flt=%b fdom=%0d",
                                 cur.t, cur.dom, cur.clamp, cur.ag, cur.busy, cur.flt, cur.fdom);
                    end
                end
            end
            prev      = cur;
            have_prev = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: expected output snapshots with their cycles
    // ------------------------------------------------------------------
    task automatic emit(input int t);
        ev_t e;
        e   = mdl;
        e.t = t;
        if (!same_vals(e, last_push)) begin
            exp_q.push_back(e);
            last_push = e;
        end
    endtask

    task automatic mdl_fault(input int i);
        mdl.dom = '0; mdl.clamp = '1; mdl.ag = 1'b0; mdl.busy = 1'b0;
        mdl.flt = 1'b1; mdl.fdom = 2'(i);
    endtask

    // Power-up from OFF with req raised at cycle t_req. Stops after enabling
    // abort_idx, or at a timeout fault. t_out = cycle of the last event.
    task automatic model_up(input int t_req, input int abort_idx, output int t_out);
        int t;
        t = t_req + 1;
        mdl.busy = 1'b1;
        emit(t);
        for (int i = 0; i < ND; i++) begin
            t = t + 1;
            mdl.dom[i] = 1'b1;
            emit(t);
            t_dom[i] = t;
            if (i == abort_idx) begin
                t_out = t;
                return;
            end
            if (hold[i]) begin
                t = t + TOUT;
                mdl_fault(i);
                emit(t);
                t_out = t;
                return;
            end
            // pgood delay, then synchroniser + debounce, one cycle to notice, settle
            t = t + d[i] + DEB + 2 + STEP;
            mdl.clamp[i] = 1'b0;
            if (i == ND - 1) begin
                mdl.ag   = 1'b1;
                mdl.busy = 1'b0;
            end
            emit(t);
        end
        t_out = t;
    endtask

    // Power-down from req dropped at t_drop, unwinding start_idx..0.
    task automatic model_down(input int t_drop, input int start_idx, output int t_out);
        int t;
        t = t_drop + 1;
        mdl.ag   = 1'b0;
        mdl.busy = 1'b1;
        emit(t);
        for (int i = start_idx; i >= 0; i--) begin
            t = t + 1;
            mdl.clamp[i] = 1'b1;
            emit(t);
            t = t + STEP;
            mdl.dom[i] = 1'b0;
            if (i == 0) mdl.busy = 1'b0;
            emit(t);
        end
        t_out = t;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic rand_delays();
        for (int i = 0; i < ND; i++) d[i] = $urandom_range(3, 15);
    endtask

    // Fault exit: a clear with req high is ignored, then req low + clear -> OFF.
    task automatic clear_fault();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (3) @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        mdl = reset_ev;
        emit(cyc + 1);
        @(negedge clk); clr = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int t;
        int tr;
        int len;
        ev_t s;
        rst = 1'b1; req = 1'b0; clr = 1'b0; hold = '0; force_low = '0;
        for (int i = 0; i < ND; i++) d[i] = 10;
        reset_ev.t = 0; reset_ev.dom = '0; reset_ev.clamp = '1; reset_ev.ag = 1'b0;
        reset_ev.busy = 1'b0; reset_ev.flt = 1'b0; reset_ev.fdom = 2'd0;
        mdl = reset_ev;
        last_push = reset_ev;

        repeat (3) @(negedge clk);
        s = sample();
        compared++;
        if (!same_vals(s, reset_ev)) begin
            mismatched++;
            show_fail("reset_state", s, reset_ev);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Normal power-up / power-down cycles with random pgood delays.
        for (int r = 0; r < 2; r++) begin
            rand_delays();
            req = 1'b1;
            model_up(cyc, ND, t);
            wait_until(t + 5);
            req = 1'b0;
            model_down(cyc, ND - 1, t);
            wait_until(t + 20);
        end

        // Glitch then brown-out in ON; domain 1 (optionally with 3) drops.
        rand_delays();
        req = 1'b1;
        model_up(cyc, ND, t);
        wait_until(t + 5);
        len = $urandom_range(1, DEB - 1);
        force_low[1] = 1'b1;
        repeat (len) @(negedge clk);
        force_low[1] = 1'b0;
        repeat (12) @(negedge clk);
        len = $urandom_range(DEB, DEB + 3);
        force_low = 4'b0010 | ($urandom_range(0, 1) ? 4'b1000 : 4'b0000);
        mdl_fault(1);
        emit(cyc + DEB + 3);
        repeat (len) @(negedge clk);
        force_low = '0;
        repeat (DEB + 6) @(negedge clk);
        clear_fault();

        // Timeout on domain 2.
        rand_delays();
        hold[2] = 1'b1;
        req = 1'b1;
        model_up(cyc, ND, t);
        wait_until(t + 3);
        clear_fault();
        hold[2] = 1'b0;

        // Abort while waiting on domain 2.
        rand_delays();
        req = 1'b1;
        model_up(cyc, 2, t);
        wait_until(t + 3);
        req = 1'b0;
        model_down(cyc, 2, t);
        wait_until(t + 20);

        // Reset pulsed while domain 1 is settling.
        rand_delays();
        req = 1'b1;
        model_up(cyc, ND, t);
        tr = t_dom[1] + d[1] + DEB + 2 + 3;
        while (exp_q.size() > 0 && exp_q[$].t > tr) void'(exp_q.pop_back());
        if (exp_q.size() > 0) last_push = exp_q[$];
        mdl = reset_ev;
        emit(tr + 1);
        wait_until(tr);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        while (exp_q.size() > 0) begin
            s = sample();
            compared++;
            mismatched++;
            show_fail("missing_event", s, exp_q[0]);
            void'(exp_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
